// File: rtl/fifo_serial_tx.sv
// rtl/fifo_serial_tx.sv - FIFO read-side consumer serialising words as UART-style frames
module fifo_serial_tx #(
  parameter int WIDTH = 4,
  parameter int DIV   = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             empty,
  output logic             rd_rq,
  input  logic [WIDTH-1:0] rdata,
  output logic             tx,
  output logic             busy,
  output logic [CNT_W-1:0] frames
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, STOP} state_t;

  state_t           state_q;
  logic [DW-1:0]    div_q;
  logic [BW-1:0]    bit_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_nxt;
  logic             tx_q;
  logic             rd_rq_q;
  logic             busy_q;
  logic [CNT_W-1:0] frames_q;

  // Next data bit is taken from the shifted word so tx stays registered
  assign shift_nxt = shift_q >> 1;

  // Frame sequencer: state, bit timing and every output advance together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      rd_rq_q  <= 1'b0;
      busy_q   <= 1'b0;
      frames_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q    <= 1'b1;
          rd_rq_q <= 1'b0;
          if (enable && !empty) begin
            state_q <= POP;
            rd_rq_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        POP: begin
          // the FIFO drives the popped word during the following cycle
          rd_rq_q <= 1'b0;
          state_q <= LOAD;
        end
        LOAD: begin
          shift_q <= rdata;
          tx_q    <= 1'b0;
          div_q   <= '0;
          state_q <= START;
        end
        START: begin
          if (div_q == DIV_LAST) begin
            div_q   <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        DATA: begin
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            if (bit_q == BIT_LAST) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              shift_q <= shift_nxt;
              tx_q    <= shift_nxt[0];
              bit_q   <= bit_q + BW'(1);
            end
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        STOP: begin
          if (div_q == DIV_LAST) begin
            div_q    <= '0;
            frames_q <= frames_q + CNT_W'(1);
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx     = tx_q;
  assign rd_rq  = rd_rq_q;
  assign busy   = busy_q;
  assign frames = frames_q;

endmodule

// File: doc/fifo_serial_tx.md
Name: fifo_serial_tx

Overview:
Read-side consumer for the 4-bit TT FIFO (full/empty/rdata interface). Pops one word whenever the FIFO is non-empty and enabled. Serialises each word onto a single-wire, UART-style frame: start bit 0, data LSB first, stop bit 1. Sits between the FIFO read port and an output pin; replaces the bench-side reader model with real hardware.

Parameters:
WIDTH, 4, data word width; matches FIFO WIDTH.
DIV, 4, clk cycles per serial bit (>=2).
CNT_W, 8, width of the frame counter.

Ports:
clk  input  1  system clock; all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
enable  input  1  permits new pops; a frame in progress always completes.
empty  input  1  FIFO empty flag.
rd_rq  output  1  FIFO read request; one-cycle pulse per pop.
rdata  input  WIDTH  FIFO read data; valid the cycle after rd_rq is high.
tx  output  1  serial line; idles high.
busy  output  1  high in every state except IDLE.
frames  output  CNT_W  count of completed frames; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, rst_n=0), applied immediately and at any point mid-frame:
  - tx=1, rd_rq=0, busy=0, frames=0, state=IDLE, shift register and counters cleared.
  - A pending or in-flight word is discarded.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, POP, LOAD, START, DATA, STOP.
- IDLE: tx=1, rd_rq=0.
  - enable=1 and empty=0 sampled on an edge -> POP.
  - Otherwise remain in IDLE.
- POP (1 cycle): rd_rq=1. Next state LOAD unconditionally. The empty flag is not re-checked.
- LOAD (1 cycle): rd_rq=0. The rdata value present during this cycle is captured into the WIDTH-bit shift register at the end of the cycle. Next state START.
- START: tx=0 for DIV cycles. The bit counter cycles 0..DIV-1, then DATA.
- DATA: tx=shift[0] for DIV cycles per bit.
  - Shift right by one after each bit period.
  - After WIDTH bits -> STOP.
- STOP: tx=1 for DIV cycles.
  - On the final cycle: frames increments by 1 (CNT_W-bit wrap, e.g. 255 -> 0), then IDLE.
- Latency:
  - The edge that samples (enable & !empty) in IDLE is followed by rd_rq high for the next cycle.
  - The tx falling edge occurs 2 cycles after rd_rq rises.
  - Frame length on tx: (WIDTH+2)*DIV cycles (24 at defaults).
- Back-to-back with FIFO continuously non-empty: IDLE lasts exactly 1 cycle. Pop-to-pop period is 3+(WIDTH+2)*DIV cycles (27 at defaults).
- Exactly one rd_rq pulse per frame. rd_rq is never high when the preceding IDLE sample saw empty=1.
- enable deasserted mid-frame: the current frame finishes normally, then the block holds IDLE.
- empty rising during POP/LOAD: ignored. The popped word is still sent.
- The full flag is not used by this block.
- busy=1 in POP, LOAD, START, DATA and STOP.

Test Plan:
1. Single word: FIFO holds 0xA, enable=1 -> one rd_rq pulse; 2 cycles later tx = 0,0,1,0,1,1, each level held 4 cycles; frames 0->1; busy low after 24+2 cycles.
2. Back-to-back: FIFO holds 0x3,0xC,0xF -> three rd_rq pulses exactly 27 cycles apart; tx data bits 1100, 0011, 1111 (LSB first); frames=3; no pop once empty=1.
3. Enable gating: enable=0 with FIFO non-empty for 100 cycles -> rd_rq never high, tx=1. Drop enable 5 cycles into a frame of 0x5 -> frame completes (bits 1010), then no further pop.
4. Empty handling: empty=1 throughout -> tx=1, busy=0, rd_rq=0 indefinitely. empty drops for 1 cycle then rises -> exactly one pop and one frame.
5. Reset mid-frame: assert rst_n=0 during DATA of 0x6 -> tx=1, busy=0, rd_rq=0 immediately (asynchronous); after release, no residual bits; the next frame starts only after a fresh pop.
6. Counter wrap: send 256 frames of 0x1 -> frames reads 255 after frame 255 and 0 after frame 256.
